// File: rtl/matmul_pkg.sv
// Shared types and default sizing for the matmul job sequencer slice.
package matmul_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 10;
  localparam int DEF_MATRIX_SIZE = 1024;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    RUN,
    WAIT,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/matmul_job_ctrl_if.sv
// Host stream, operand BRAM write port, engine handshake and result stream of the job sequencer.
interface matmul_job_ctrl_if
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                  job_start;
  logic                  busy;
  logic                  job_done;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  x_wr_en;
  logic                  y_wr_en;
  logic                  mm_start;
  logic                  mm_done;
  logic [ADDR_WIDTH-1:0] z_rd_addr;
  logic [DATA_WIDTH-1:0] z_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport slave (
    input  job_start, in_valid, in_data, mm_done, z_dout, out_ready,
    output busy, job_done, in_ready, mem_wr_addr, mem_wr_data, x_wr_en, y_wr_en,
           mm_start, z_rd_addr, out_valid, out_data
  );

  modport master (
    output job_start, in_valid, in_data, mm_done, z_dout, out_ready,
    input  busy, job_done, in_ready, mem_wr_addr, mem_wr_data, x_wr_en, y_wr_en,
           mm_start, z_rd_addr, out_valid, out_data
  );

endinterface

// File: rtl/matmul_drain_skid.sv
// Two-entry result skid buffer; reserves a slot for the read in flight so BRAM data never overflows.
module matmul_drain_skid #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rd_issue,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  room,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  vld_p1;
  logic [1:0]            occ;
  logic [1:0]            used;
  logic [DATA_WIDTH-1:0] e0, e1;
  logic                  push, pop;

  assign push      = vld_p1;
  assign pop       = out_valid & out_ready;
  assign used      = occ + {1'b0, vld_p1};
  // A pop this cycle frees a slot in time for the read issued now.
  assign room      = (used < 2'd2) | pop;
  assign out_valid = (occ != 2'd0);
  assign out_data  = out_valid ? e0 : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      occ    <= 2'd0;
    end else begin
      vld_p1 <= rd_issue;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // p1 boundary: BRAM read data lands in the entry behind the current head.
  always_ff @(posedge clock) begin
    case ({push, pop})
      2'b10: begin
        if (occ == 2'd0) e0 <= rd_data;
        else             e1 <= rd_data;
      end
      2'b01: e0 <= e1;
      2'b11: begin
        if (occ == 2'd1) begin
          e0 <= rd_data;
        end else begin
          e0 <= e1;
          e1 <= rd_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/matmul_job_ctrl.sv
// Job sequencer: loads X then Y from the host stream, kicks the engine, drains Z to the output stream.
module matmul_job_ctrl
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE
) (
  input logic              clock,
  input logic              reset,
  matmul_job_ctrl_if.slave bus
);

  localparam int             CW   = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]  LAST = CW'(MATRIX_SIZE - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rd_cnt;
  logic          rd_last;
  logic          busy_r, in_ready_r, mm_start_r, job_done_r;
  logic          accept, rd_issue, room, pop;

  assign accept          = bus.in_valid & in_ready_r;
  assign bus.x_wr_en     = accept & (state == LOAD_X);
  assign bus.y_wr_en     = accept & (state == LOAD_Y);
  assign bus.mem_wr_addr = cnt[ADDR_WIDTH-1:0];
  assign bus.mem_wr_data = in_ready_r ? bus.in_data : '0;
  assign bus.busy        = busy_r;
  assign bus.in_ready    = in_ready_r;
  assign bus.mm_start    = mm_start_r;
  assign bus.job_done    = job_done_r;
  assign bus.z_rd_addr   = rd_cnt[ADDR_WIDTH-1:0];
  assign rd_issue        = (state == DRAIN) & room & ~rd_last;
  assign pop             = bus.out_valid & bus.out_ready;

  matmul_drain_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .rd_issue  (rd_issue),
    .rd_data   (bus.z_dout),
    .room      (room),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_data)
  );

  // cnt counts load accepts in LOAD_X/LOAD_Y and output accepts in DRAIN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_cnt     <= '0;
      rd_last    <= 1'b0;
      busy_r     <= 1'b0;
      in_ready_r <= 1'b0;
      mm_start_r <= 1'b0;
      job_done_r <= 1'b0;
    end else begin
      mm_start_r <= 1'b0;
      job_done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.job_start) begin
            state      <= LOAD_X;
            busy_r     <= 1'b1;
            in_ready_r <= 1'b1;
          end
        end
        LOAD_X: begin
          if (accept) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= LOAD_Y;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        LOAD_Y: begin
          if (accept) begin
            if (cnt == LAST) begin
              cnt        <= '0;
              state      <= RUN;
              in_ready_r <= 1'b0;
              mm_start_r <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        RUN: state <= WAIT;
        WAIT: begin
          if (bus.mm_done) state <= DRAIN;
        end
        DRAIN: begin
          // The read address parks on the last word rather than running past it.
          if (rd_issue) begin
            if (rd_cnt == LAST) rd_last <= 1'b1;
            else                rd_cnt  <= rd_cnt + ONE;
          end
          if (pop) begin
            if (cnt == LAST) begin
              cnt        <= '0;
              state      <= DONE;
              job_done_r <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          busy_r  <= 1'b0;
          rd_cnt  <= '0;
          rd_last <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
